dm_port_arbiter: RTL and testbench



---
 rtl/dm_arb_pkg.sv | 18 +
 rtl/dm_lane_steer.sv | 45 ++++
 rtl/dm_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_dm_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Optional statistics counters are enabled with DM_ARB_STATS_EN.
package dm_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_C,
        SERVE_D
    } arb_state_t;

    localparam int DEV_LO_DEF = 1984;
    localparam int DEV_HI_DEF = 1990;

endpackage

// File: rtl/dm_lane_steer.sv
// Byte-enable, write-data replication, load extraction and
// misalignment detection for one muxed memory access.
module dm_lane_steer
    import dm_arb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wd,
    input  logic [31:0] rd_raw,
    output logic [3:0]  be,
    output logic [31:0] wd_rep,
    output logic [31:0] rd,
    output logic        misal
);

    logic [31:0] rd_sh;

    always_comb begin
        be     = 4'b1111;
        wd_rep = wd;
        rd     = rd_raw;
        misal  = 1'b0;
        rd_sh  = rd_raw >> {off, 3'b000};
        unique case (1'b1)
            (size == SZ_BYTE): begin
                be     = 4'b0001 << off;
                wd_rep = {4{wd[7:0]}};
                rd     = {24'b0, rd_sh[7:0]};
            end
            (size == SZ_HALF): begin
                be     = off[1] ? 4'b1100 : 4'b0011;
                wd_rep = {2{wd[15:0]}};
                rd     = {16'b0, off[1] ? rd_raw[31:16] : rd_raw[15:0]};
                misal  = off[0];
            end
            default: begin
                misal = (off != 2'b00);
            end
        endcase
        if (misal) begin
            rd = 32'b0;
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Round-robin sharing of the data-memory port between the CPU MEM stage
// (C) and the loader (D); DM_ARB_STATS_EN adds grant/conflict counters.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int DEV_LO    = DEV_LO_DEF,
    parameter int DEV_HI    = DEV_HI_DEF
`ifdef DM_ARB_STATS_EN
    ,
    parameter int STAT_W    = 16
`endif
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wd,
    input  logic [1:0]  c_size,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wd,
    input  logic [1:0]  d_size,
    input  logic        d_lock,
    input  logic        Exception,
    output logic        c_ack,
    output logic        c_err,
    output logic [31:0] c_rd,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rd,
    output logic [10:0] dm_A,
    output logic [31:0] dm_WD,
    output logic [3:0]  dm_BE,
    output logic        dm_WE,
    input  logic [31:0] dm_RD,
    output logic        dev_WE,
    input  logic [31:0] dev_RD
`ifdef DM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_c_grants,
    output logic [STAT_W-1:0] stat_d_grants,
    output logic [STAT_W-1:0] stat_conflicts
`endif
);

    localparam int         BW  = $clog2(MAX_BURST + 1);
    localparam logic [10:0] DLO = 11'(DEV_LO);
    localparam logic [10:0] DHI = 11'(DEV_HI);

    arb_state_t    state, state_n;
    logic          rr_last, rr_n;
    logic [BW-1:0] beat_cnt, beat_n;

    logic          act, sel_d;
    logic          r_we;
    logic [31:0]   r_addr, r_wd;
    logic [1:0]    r_size;
    logic [10:0]   widx;
    logic          in_dev, kill, wr_ok;
    logic [3:0]    be;
    logic [31:0]   wd_rep, rdo;
    logic          misal;
    logic          unused_hi;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            rr_last  <= 1'b1;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            rr_last  <= rr_n;
            beat_cnt <= beat_n;
        end
    end

    always_comb begin
        state_n = state;
        rr_n    = rr_last;
        beat_n  = beat_cnt;
        unique case (state)
            IDLE: begin
                beat_n = '0;
                if (c_req && d_req) begin
                    state_n = rr_last ? SERVE_C : SERVE_D;
                end else if (c_req) begin
                    state_n = SERVE_C;
                end else if (d_req) begin
                    state_n = SERVE_D;
                end
            end
            SERVE_C: begin
                rr_n   = 1'b0;
                beat_n = '0;
                if (d_req) begin
                    state_n = SERVE_D;
                end else if (c_req) begin
                    state_n = SERVE_C;
                end else begin
                    state_n = IDLE;
                end
            end
            SERVE_D: begin
                rr_n = 1'b1;
                // a locked burst holds the port until the beat limit
                if (d_lock && d_req &&
                    (beat_cnt + BW'(1) < BW'(MAX_BURST))) begin
                    state_n = SERVE_D;
                    beat_n  = beat_cnt + BW'(1);
                end else begin
                    beat_n = '0;
                    if (c_req) begin
                        state_n = SERVE_C;
                    end else if (d_req) begin
                        state_n = SERVE_D;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign act    = (state != IDLE);
    assign sel_d  = (state == SERVE_D);
    assign r_we   = sel_d ? d_we   : c_we;
    assign r_addr = sel_d ? d_addr : c_addr;
    assign r_wd   = sel_d ? d_wd   : c_wd;
    assign r_size = sel_d ? d_size : c_size;
    assign widx   = r_addr[12:2];
    assign in_dev = (widx >= DLO) && (widx <= DHI);

    dm_lane_steer u_steer (
        .size   (r_size),
        .off    (r_addr[1:0]),
        .wd     (r_wd),
        .rd_raw (in_dev ? dev_RD : dm_RD),
        .be     (be),
        .wd_rep (wd_rep),
        .rd     (rdo),
        .misal  (misal)
    );

    // a CPU exception squashes only the CPU's own store
    assign kill  = !sel_d && Exception;
    assign wr_ok = act && r_we && !misal && !kill;

    assign dm_WE  = wr_ok && !in_dev;
    assign dev_WE = wr_ok && in_dev;
    assign dm_A   = act ? widx   : 11'b0;
    assign dm_WD  = act ? wd_rep : 32'b0;
    assign dm_BE  = act ? be     : 4'b0;

    assign c_ack = (state == SERVE_C);
    assign d_ack = sel_d;
    assign c_err = c_ack && misal;
    assign d_err = d_ack && misal;
    assign c_rd  = c_ack ? rdo : 32'b0;
    assign d_rd  = d_ack ? rdo : 32'b0;

    assign unused_hi = ^{c_addr[31:13], d_addr[31:13]};

`ifdef DM_ARB_STATS_EN
    logic conflict;

    assign conflict = (c_req && state != SERVE_C) ||
                      (d_req && state != SERVE_D);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stat_c_grants  <= '0;
            stat_d_grants  <= '0;
            stat_conflicts <= '0;
        end else begin
            if (c_ack && !(&stat_c_grants)) begin
                stat_c_grants <= stat_c_grants + STAT_W'(1);
            end
            if (d_ack && !(&stat_d_grants)) begin
                stat_d_grants <= stat_d_grants + STAT_W'(1);
            end
            if (conflict && !(&stat_conflicts)) begin
                stat_conflicts <= stat_conflicts + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: vector table plus arbitration sequences,
// checked through an expected-ack scoreboard.
module tb_dm_port_arbiter;
    import dm_arb_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        c_req, c_we, d_req, d_we, d_lock, Exception;
    logic [31:0] c_addr, c_wd, d_addr, d_wd;
    logic [1:0]  c_size, d_size;
    logic        c_ack, c_err, d_ack, d_err;
    logic [31:0] c_rd, d_rd;
    logic [10:0] dm_A;
    logic [31:0] dm_WD, dm_RD, dev_RD;
    logic [3:0]  dm_BE;
    logic        dm_WE, dev_WE;

    always #5 Clk = ~Clk;

    dm_port_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wd(c_wd),
        .c_size(c_size),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd),
        .d_size(d_size), .d_lock(d_lock), .Exception(Exception),
        .c_ack(c_ack), .c_err(c_err), .c_rd(c_rd),
        .d_ack(d_ack), .d_err(d_err), .d_rd(d_rd),
        .dm_A(dm_A), .dm_WD(dm_WD), .dm_BE(dm_BE), .dm_WE(dm_WE),
        .dm_RD(dm_RD), .dev_WE(dev_WE), .dev_RD(dev_RD)
    );

    logic [31:0] mem [0:2047];
    logic        mem_clr;

    assign dm_RD  = mem[dm_A];
    assign dev_RD = 32'hD000_0000 | {21'b0, dm_A};

    always @(posedge Clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 32'b0;
        end else if (dm_WE) begin
            for (int b = 0; b < 4; b++)
                if (dm_BE[b]) mem[dm_A][8*b +: 8] <= dm_WD[8*b +: 8];
        end
    end

    typedef struct {
        logic        port;
        logic        err;
        logic        dmwe;
        logic        devwe;
        logic        chk_lane;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [10:0] a;
        logic        chk_rd;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  size;
        logic        exc;
        exp_t        e;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset) begin
            if (c_ack || d_ack) begin : ack_chk
                exp_t e;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got c=%0b d=%0b expected none",
                             c_ack, d_ack);
                end else begin
                    e = sbq.pop_front();
                    chk("ack_port", {31'b0, d_ack}, {31'b0, e.port});
                    chk("ack_both", {31'b0, c_ack & d_ack}, 32'd0);
                    chk("err", {31'b0, e.port ? d_err : c_err},
                        {31'b0, e.err});
                    chk("dm_WE", {31'b0, dm_WE}, {31'b0, e.dmwe});
                    chk("dev_WE", {31'b0, dev_WE}, {31'b0, e.devwe});
                    chk("dm_A", {21'b0, dm_A}, {21'b0, e.a});
                    if (e.chk_lane) begin
                        chk("dm_BE", {28'b0, dm_BE}, {28'b0, e.be});
                        chk("dm_WD", dm_WD, e.wd);
                    end
                    if (e.chk_rd)
                        chk("rd", e.port ? d_rd : c_rd, e.rd);
                end
            end else begin
                chk("idle_dm_WE", {31'b0, dm_WE}, 32'd0);
                chk("idle_dev_WE", {31'b0, dev_WE}, 32'd0);
            end
        end
    end

    function automatic exp_t mk(input logic port, input logic [31:0] addr,
                                input logic err, input logic dmwe,
                                input logic devwe, input logic chk_lane,
                                input logic [3:0] be, input logic [31:0] wd,
                                input logic chk_rd, input logic [31:0] rd);
        exp_t e;
        e.port = port;  e.err = err;  e.dmwe = dmwe;  e.devwe = devwe;
        e.chk_lane = chk_lane;  e.be = be;  e.wd = wd;
        e.a = addr[12:2];  e.chk_rd = chk_rd;  e.rd = rd;
        return e;
    endfunction

    function automatic exp_t ldw(input logic port, input logic [31:0] addr,
                                 input logic [31:0] rd);
        return mk(port, addr, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 32'h0,
                  1'b1, rd);
    endfunction

    task automatic add(input logic port, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] size, input logic exc,
                       input logic err, input logic dmwe, input logic devwe,
                       input logic chk_lane, input logic [3:0] be,
                       input logic [31:0] wdr, input logic chk_rd,
                       input logic [31:0] rd);
        vec_t v;
        v.port = port;  v.we = we;  v.addr = addr;  v.wd = wd;
        v.size = size;  v.exc = exc;
        v.e = mk(port, addr, err, dmwe, devwe, chk_lane, be, wdr,
                 chk_rd, rd);
        vt.push_back(v);
    endtask

    task automatic access(input vec_t v);
        int n;
        @(negedge Clk);
        Exception = v.exc;
        if (v.port) begin
            d_we = v.we;  d_addr = v.addr;  d_wd = v.wd;  d_size = v.size;
            d_req = 1'b1;
        end else begin
            c_we = v.we;  c_addr = v.addr;  c_wd = v.wd;  c_size = v.size;
            c_req = 1'b1;
        end
        sbq.push_back(v.e);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!(v.port ? d_ack : c_ack) && n < 8);
        chk("latency", n, 1);
        c_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic set_loads(input logic [31:0] ca, input logic [31:0] da);
        c_we = 1'b0;  c_addr = ca;  c_wd = 32'h0;  c_size = SZ_WORD;
        d_we = 1'b0;  d_addr = da;  d_wd = 32'h0;  d_size = SZ_WORD;
        Exception = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;  mem_clr = 1'b1;
        c_req = 0; c_we = 0; c_addr = 0; c_wd = 0; c_size = SZ_BYTE;
        d_req = 0; d_we = 0; d_addr = 0; d_wd = 0; d_size = SZ_BYTE;
        d_lock = 0; Exception = 0;

        //   port we addr         wd           size     exc err dm dev lane be    wd_out       rd? rd
        add(0, 1, 32'h10,   32'hDEADBEEF, SZ_WORD, 0, 0, 1, 0, 1, 4'hF, 32'hDEADBEEF, 0, 0);
        add(0, 0, 32'h10,   32'h0,        SZ_WORD, 0, 0, 0, 0, 1, 4'hF, 32'h0,        1, 32'hDEADBEEF);
        add(0, 1, 32'h13,   32'hAB,       SZ_BYTE, 0, 0, 1, 0, 1, 4'h8, 32'hABABABAB, 0, 0);
        add(0, 0, 32'h12,   32'h0,        SZ_HALF, 0, 0, 0, 0, 1, 4'hC, 32'h0,        1, 32'h0000ABAD);
        add(0, 0, 32'h11,   32'h0,        SZ_BYTE, 0, 0, 0, 0, 1, 4'h2, 32'h0,        1, 32'h000000BE);
        add(0, 1, 32'h22,   32'h1234,     SZ_HALF, 0, 0, 1, 0, 1, 4'hC, 32'h12341234, 0, 0);
        add(0, 0, 32'h20,   32'h0,        SZ_WORD, 0, 0, 0, 0, 1, 4'hF, 32'h0,        1, 32'h12340000);
        add(1, 1, 32'h21,   32'h5678,     SZ_HALF, 0, 1, 0, 0, 0, 4'h0, 32'h0,        0, 0);
        add(0, 0, 32'h21,   32'h0,        SZ_WORD, 0, 1, 0, 0, 0, 4'h0, 32'h0,        1, 32'h0);
        add(0, 1, 32'h1F04, 32'hCAFEF00D, SZ_WORD, 0, 0, 0, 1, 1, 4'hF, 32'hCAFEF00D, 0, 0);
        add(0, 0, 32'h1F04, 32'h0,        SZ_WORD, 0, 0, 0, 0, 1, 4'hF, 32'h0,        1, 32'hD00007C1);
        add(0, 1, 32'h10,   32'h11111111, SZ_WORD, 1, 0, 0, 0, 0, 4'h0, 32'h0,        0, 0);
        add(0, 0, 32'h10,   32'h0,        SZ_WORD, 0, 0, 0, 0, 1, 4'hF, 32'h0,        1, 32'hABADBEEF);
        add(0, 0, 32'h20,   32'h0,        2'b11,   0, 0, 0, 0, 1, 4'hF, 32'h0,        1, 32'h12340000);
        add(1, 1, 32'h1EFC, 32'h77,       SZ_WORD, 0, 0, 1, 0, 1, 4'hF, 32'h77,       0, 0);
        add(1, 1, 32'h1F00, 32'h88,       SZ_WORD, 1, 0, 0, 1, 1, 4'hF, 32'h88,       0, 0);
        add(0, 1, 32'h1F18, 32'h99,       SZ_WORD, 0, 0, 0, 1, 1, 4'hF, 32'h99,       0, 0);
        add(0, 1, 32'h1F1C, 32'hAA,       SZ_WORD, 0, 0, 1, 0, 1, 4'hF, 32'hAA,       0, 0);
        add(1, 0, 32'h1EFC, 32'h0,        SZ_BYTE, 0, 0, 0, 0, 1, 4'h1, 32'h0,        1, 32'h77);
        add(1, 1, 32'h41,   32'h5A,       SZ_BYTE, 0, 0, 1, 0, 1, 4'h2, 32'h5A5A5A5A, 0, 0);
        add(0, 0, 32'h40,   32'h0,        SZ_HALF, 0, 0, 0, 0, 1, 4'h3, 32'h0,        1, 32'h00005A00);
        add(0, 0, 32'h1F07, 32'h0,        SZ_BYTE, 0, 0, 0, 0, 1, 4'h8, 32'h0,        1, 32'h000000D0);

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_c_ack", {31'b0, c_ack}, 32'd0);
        chk("rst_d_ack", {31'b0, d_ack}, 32'd0);
        chk("rst_errs", {30'b0, c_err, d_err}, 32'd0);
        chk("rst_strobes", {30'b0, dm_WE, dev_WE}, 32'd0);
        chk("rst_dm_A", {21'b0, dm_A}, 32'd0);
        chk("rst_dm_WD", dm_WD, 32'd0);
        chk("rst_dm_BE", {28'b0, dm_BE}, 32'd0);
        Reset = 1'b0;
        mem_clr = 1'b0;

        foreach (vt[i]) access(vt[i]);

        chk("dev_no_mem_1", mem[11'h7C1], 32'h0);
        chk("dev_no_mem_2", mem[11'h7C6], 32'h0);
        chk("mem_above_win", mem[11'h7C7], 32'hAA);
        chk("mem_below_win", mem[11'h7BF], 32'h77);

        // both pending after a C grant: D first, then alternate
        @(negedge Clk);
        set_loads(32'h10, 32'h20);
        c_req = 1'b1;  d_req = 1'b1;
        sbq.push_back(ldw(1, 32'h20, 32'h12340000));
        sbq.push_back(ldw(0, 32'h10, 32'hABADBEEF));
        sbq.push_back(ldw(1, 32'h20, 32'h12340000));
        sbq.push_back(ldw(0, 32'h10, 32'hABADBEEF));
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("alt_ack", {31'b0, c_ack | d_ack}, 32'd1);
        end
        c_req = 1'b0;  d_req = 1'b0;

        // locked burst with C pending: four D beats then C
        @(negedge Clk);
        d_lock = 1'b1;  c_req = 1'b1;  d_req = 1'b1;
        for (int i = 0; i < 4; i++) sbq.push_back(ldw(1, 32'h20, 32'h12340000));
        sbq.push_back(ldw(0, 32'h10, 32'hABADBEEF));
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("lock_ack", {30'b0, c_ack, d_ack}, (i < 4) ? 32'd1 : 32'd2);
        end
        c_req = 1'b0;  d_req = 1'b0;

        // unopposed locked D runs past the beat limit
        @(negedge Clk);
        d_req = 1'b1;
        for (int i = 0; i < 6; i++) sbq.push_back(ldw(1, 32'h20, 32'h12340000));
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            chk("unopp_d_ack", {31'b0, d_ack}, 32'd1);
        end
        d_req = 1'b0;  d_lock = 1'b0;

        // reset in the middle of a D store
        @(negedge Clk);
        d_we = 1'b1;  d_addr = 32'h30;  d_wd = 32'h55555555;
        d_size = SZ_WORD;  d_req = 1'b1;
        @(posedge Clk);
        #1;
        chk("pre_rst_d_ack", {31'b0, d_ack}, 32'd1);
        Reset = 1'b1;
        #1;
        chk("rst_kill_ack", {31'b0, d_ack}, 32'd0);
        chk("rst_kill_we", {31'b0, dm_WE}, 32'd0);
        d_req = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        chk("rst_hold_ack", {31'b0, d_ack}, 32'd0);
        chk("rst_hold_A", {21'b0, dm_A}, 32'd0);
        Reset = 1'b0;
        chk("rst_no_write", mem[12], 32'h0);

        // after reset C wins the first tie
        @(negedge Clk);
        set_loads(32'h30, 32'h10);
        c_req = 1'b1;  d_req = 1'b1;
        sbq.push_back(ldw(0, 32'h30, 32'h0));
        sbq.push_back(ldw(1, 32'h10, 32'hABADBEEF));
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            chk("tie_ack", {30'b0, c_ack, d_ack}, (i == 0) ? 32'd2 : 32'd1);
        end
        c_req = 1'b0;  d_req = 1'b0;

        repeat (3) @(negedge Clk);
        chk("sb_empty", sbq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
